// File: rtl/gpu_cmd_scheduler.sv
// Command sequencer between the APB command slave and the raster engine:
// command FIFO, start/end/color state, job dispatch and front/back buffer selection.
module gpu_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int XW         = 9,
  parameter int YW         = 8,
  parameter int XMAX       = 320,
  parameter int YMAX       = 240,
  parameter int COLOR_W    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [26:0]        cmd_data,
  output logic               cmd_ready,
  output logic               job_start,
  output logic               job_type,
  output logic [XW-1:0]      job_x0,
  output logic [YW-1:0]      job_y0,
  output logic [XW-1:0]      job_x1,
  output logic [YW-1:0]      job_y1,
  output logic [COLOR_W-1:0] job_color,
  output logic [8:0]         job_y_offset,
  input  logic               job_done,
  output logic               disp_buf,
  output logic               flip_pulse,
  output logic               busy
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [XW:0] XLIM = (XW+1)'(XMAX);
  localparam logic [YW:0] YLIM = (YW+1)'(YMAX);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_DONE} state_t;
  typedef enum logic [2:0] {
    OP_CLEAR, OP_SET_START, OP_SET_END, OP_SET_COLOR,
    OP_MOVE_START, OP_MOVE_END, OP_DRAW, OP_FLIP
  } op_t;

  state_t state, next_state;

  logic [26:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  logic [26:0]        cmd_reg;
  logic [XW-1:0]      start_x, end_x;
  logic [YW-1:0]      start_y, end_y;
  logic [COLOR_W-1:0] color;

  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (count != '0) | (state != IDLE);

  // ---------------- command FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- decode / move arithmetic ----------------
  op_t           op;
  logic [XW-1:0] d_x, base_x, mv_x;
  logic [YW-1:0] d_y, base_y, mv_y;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  assign op     = op_t'(cmd_reg[26:24]);
  assign d_x    = cmd_reg[YW +: XW];
  assign d_y    = cmd_reg[YW-1:0];
  assign base_x = (op == OP_MOVE_END) ? end_x : start_x;
  assign base_y = (op == OP_MOVE_END) ? end_y : start_y;
  assign sum_x  = {1'b0, base_x} + {1'b0, d_x};
  assign sum_y  = {1'b0, base_y} + {1'b0, d_y};

  // Single conditional subtract: out-of-range SET values are only pulled back once.
  always_comb begin
    mv_x = sum_x[XW-1:0];
    mv_y = sum_y[YW-1:0];
    if (sum_x >= XLIM) mv_x = XW'(sum_x - XLIM);
    if (sum_y >= YLIM) mv_y = YW'(sum_y - YLIM);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC:      next_state = (op == OP_CLEAR || op == OP_DRAW) ? WAIT_DONE : IDLE;
      WAIT_DONE: if (job_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // ---------------- state registers and job outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg      <= '0;
      start_x      <= '0;
      start_y      <= '0;
      end_x        <= '0;
      end_y        <= '0;
      color        <= '0;
      disp_buf     <= 1'b0;
      flip_pulse   <= 1'b0;
      job_start    <= 1'b0;
      job_type     <= 1'b0;
      job_x0       <= '0;
      job_y0       <= '0;
      job_x1       <= '0;
      job_y1       <= '0;
      job_color    <= '0;
      job_y_offset <= '0;
    end else begin
      job_start  <= 1'b0;
      flip_pulse <= 1'b0;
      if (pop) cmd_reg <= mem[rd_ptr];
      if (state == EXEC) begin
        case (op)
          OP_SET_START:  begin start_x <= d_x;  start_y <= d_y;  end
          OP_SET_END:    begin end_x   <= d_x;  end_y   <= d_y;  end
          OP_SET_COLOR:  color <= cmd_reg[COLOR_W-1:0];
          OP_MOVE_START: begin start_x <= mv_x; start_y <= mv_y; end
          OP_MOVE_END:   begin end_x   <= mv_x; end_y   <= mv_y; end
          OP_FLIP:       begin disp_buf <= ~disp_buf; flip_pulse <= 1'b1; end
          default: begin
            // CLEAR / DRAW: job fields latched here and held through WAIT_DONE
            job_start    <= 1'b1;
            job_type     <= (op == OP_DRAW);
            job_x0       <= start_x;
            job_y0       <= start_y;
            job_x1       <= end_x;
            job_y1       <= end_y;
            job_color    <= color;
            job_y_offset <= disp_buf ? 9'd0 : 9'(YMAX);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Randomized self-checking bench for gpu_cmd_scheduler: an in-order command model
// predicts the job/flip event stream; a rasterizer stand-in answers job_start.
module tb_gpu_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [26:0] cmd_data = '0;
  logic        job_done = 1'b0;
  logic        cmd_ready, job_start, job_type, disp_buf, flip_pulse, busy;
  logic [8:0]  job_x0, job_x1, job_y_offset;
  logic [7:0]  job_y0, job_y1;
  logic [23:0] job_color;

  always #5 clk = ~clk;

  gpu_cmd_scheduler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .job_start(job_start), .job_type(job_type),
    .job_x0(job_x0), .job_y0(job_y0), .job_x1(job_x1), .job_y1(job_y1),
    .job_color(job_color), .job_y_offset(job_y_offset), .job_done(job_done),
    .disp_buf(disp_buf), .flip_pulse(flip_pulse), .busy(busy)
  );

  typedef struct packed {
    logic        is_flip;
    logic        typ;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  x1;
    logic [7:0]  y1;
    logic [23:0] color;
    logic [8:0]  yoff;
    logic        disp;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  cur;
  logic [8:0]  sx, ex;
  logic [7:0]  sy, ey;
  logic [23:0] mcolor;
  logic        mdisp;
  bit          outstanding = 0, hold_done = 0, spur = 0;
  int          timer = 0;

  function automatic int wrap(input int a, input int b, input int lim, input int mask);
    int s = a + b;
    if (s >= lim) s -= lim;
    return s & mask;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    sx = '0; sy = '0; ex = '0; ey = '0; mcolor = '0; mdisp = 1'b0;
  endtask

  // Commands execute strictly in order, so the event stream follows from the accepted sequence.
  task automatic apply(input logic [2:0] op, input logic [23:0] d);
    ev_t e;
    e = '0;
    case (op)
      3'd1: begin sx = d[16:8]; sy = d[7:0]; end
      3'd2: begin ex = d[16:8]; ey = d[7:0]; end
      3'd3: mcolor = d;
      3'd4: begin sx = 9'(wrap(sx, d[16:8], 320, 511)); sy = 8'(wrap(sy, d[7:0], 240, 255)); end
      3'd5: begin ex = 9'(wrap(ex, d[16:8], 320, 511)); ey = 8'(wrap(ey, d[7:0], 240, 255)); end
      3'd7: begin mdisp = ~mdisp; e.is_flip = 1'b1; e.disp = mdisp; exp_q.push_back(e); end
      default: begin
        e.typ = (op == 3'd6); e.x0 = sx; e.y0 = sy; e.x1 = ex; e.y1 = ey;
        e.color = mcolor; e.yoff = mdisp ? 9'd0 : 9'd240;
        exp_q.push_back(e);
      end
    endcase
  endtask

  // Rasterizer stand-in and event monitor
  always @(negedge clk) begin
    job_done = 1'b0;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (job_start) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].is_flip || outstanding) begin
          errors++;
          $display("FAIL job_start_unexpected q=%0d outstanding=%0d", exp_q.size(), outstanding);
        end else begin
          cur = exp_q.pop_front();
          if ({job_type, job_x0, job_y0, job_x1, job_y1, job_color, job_y_offset} !==
              {cur.typ, cur.x0, cur.y0, cur.x1, cur.y1, cur.color, cur.yoff}) begin
            errors++;
            $display("FAIL job_fields got t=%0d (%0d,%0d)-(%0d,%0d) c=%h off=%0d want t=%0d (%0d,%0d)-(%0d,%0d) c=%h off=%0d",
                     job_type, job_x0, job_y0, job_x1, job_y1, job_color, job_y_offset,
                     cur.typ, cur.x0, cur.y0, cur.x1, cur.y1, cur.color, cur.yoff);
          end
        end
        outstanding = 1;
        timer = $urandom_range(0, 3);
      end else if (outstanding) begin
        checks++;
        if ({job_type, job_x0, job_y0, job_x1, job_y1, job_color, job_y_offset} !==
            {cur.typ, cur.x0, cur.y0, cur.x1, cur.y1, cur.color, cur.yoff}) begin
          errors++;
          $display("FAIL job_hold fields changed before job_done got x0=%0d c=%h want x0=%0d c=%h",
                   job_x0, job_color, cur.x0, cur.color);
        end
        if (!hold_done) begin
          if (timer == 0) begin job_done = 1'b1; outstanding = 0; end
          else timer--;
        end
      end
      if (flip_pulse) begin
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_flip || outstanding || disp_buf !== exp_q[0].disp) begin
          errors++;
          $display("FAIL flip_event got disp_buf=%0d outstanding=%0d q=%0d want ordered flip",
                   disp_buf, outstanding, exp_q.size());
        end
        if (exp_q.size() != 0 && exp_q[0].is_flip) void'(exp_q.pop_front());
      end
      if (spur && !outstanding) job_done = 1'b1;
    end
  end

  task automatic push(input logic [2:0] op, input logic [23:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = {op, d};
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout cmd_ready=%0d required 1", cmd_ready);
    end else apply(op, d);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || outstanding || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain busy=%0d pending_events=%0d required 0/0", busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_job();
    int n = 0;
    while (!outstanding && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!outstanding) begin errors++; $display("FAIL job_wait no job_start seen, required one"); end
    @(posedge clk); #1;
  endtask

  function automatic logic [23:0] xy(input int x, input int y);
    return {7'd0, 9'(x), 8'(y)};
  endfunction

  function automatic logic [2:0] rnd_set_op();
    return 3'($urandom_range(1, 5));
  endfunction

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    checks++;
    if ({job_start, busy, cmd_ready, disp_buf, flip_pulse} !== 5'b00100 ||
        {job_type, job_x0, job_y0, job_x1, job_y1, job_color, job_y_offset} !== '0) begin
      errors++;
      $display("FAIL reset_state start=%0d busy=%0d ready=%0d disp=%0d x0=%0d c=%h want 0,0,1,0,0,0",
               job_start, busy, cmd_ready, disp_buf, job_x0, job_color);
    end
    @(posedge clk); #1; rst = 1'b0;
    hold_done = 1;
    push(3'd7, '0);
    push(3'd1, xy(50, 60));
    push(3'd6, '0);
    wait_job();
    checks++;
    if (disp_buf !== 1'b1) begin errors++; $display("FAIL pre_reset_disp got %0d want 1", disp_buf); end
    cmd_valid = 1'b1; cmd_data = {3'd3, 24'h123456};
    @(posedge clk); #1; cmd_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({job_start, busy, cmd_ready, disp_buf} !== 4'b0010) begin
      errors++;
      $display("FAIL midjob_reset start=%0d busy=%0d ready=%0d disp=%0d want 0,0,1,0",
               job_start, busy, cmd_ready, disp_buf);
    end
    model_reset();
    hold_done = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || job_start !== 1'b0) begin
      errors++;
      $display("FAIL fifo_flushed busy=%0d start=%0d want 0 0", busy, job_start);
    end
    @(posedge clk); #1;
    push(3'd0, '0);
    wait_idle();
  endtask

  task automatic test_draw();
    push(3'd3, 24'hFF0000);
    push(3'd1, xy(10, 20));
    push(3'd2, xy(300, 200));
    wait_idle();
    push(3'd6, '0);
    @(negedge clk);
    checks++;
    if (job_start !== 1'b0) begin errors++; $display("FAIL latency_early1 got %0d want 0", job_start); end
    @(negedge clk);
    checks++;
    if (job_start !== 1'b0) begin errors++; $display("FAIL latency_early2 got %0d want 0", job_start); end
    @(negedge clk);
    checks++;
    if (job_start !== 1'b1 || job_y_offset !== 9'd240 || job_x1 !== 9'd300) begin
      errors++;
      $display("FAIL latency_draw start=%0d off=%0d x1=%0d want 1 240 300", job_start, job_y_offset, job_x1);
    end
    @(posedge clk); #1;
    wait_idle();
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    hold_done = 1;
    push(3'd6, '0);
    wait_job();
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op = rnd_set_op();
      logic [23:0] d  = 24'($urandom);
      cmd_valid = 1'b1; cmd_data = {op, d};
      @(negedge clk);
      checks++;
      if (cmd_ready !== (acc < 4)) begin
        errors++;
        $display("FAIL fifo_ready push %0d got %0d want %0d", i, cmd_ready, acc < 4);
      end
      if (cmd_ready) begin apply(op, d); acc++; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full_hold ready=%0d busy=%0d want 0 1", cmd_ready, busy);
    end
    @(posedge clk); #1;
    hold_done = 0;
    push(3'd6, '0);
    wait_idle();
  endtask

  task automatic test_move();
    push(3'd1, xy(310, 230));
    push(3'd4, xy(20, 15));
    push(3'd0, '0);
    wait_idle();
    checks++;
    if (job_x0 !== 9'd10 || job_y0 !== 8'd5) begin
      errors++;
      $display("FAIL move_wrap got (%0d,%0d) want (10,5)", job_x0, job_y0);
    end
    for (int i = 0; i < 12; i++) push(rnd_set_op(), 24'($urandom));
    push(3'd6, '0);
    push(3'd2, xy(511, 255));
    push(3'd5, xy(511, 255));
    push(3'd0, '0);
    wait_idle();
  endtask

  task automatic test_flip_order();
    logic d0;
    d0 = disp_buf;
    hold_done = 1;
    push(3'd6, '0);
    push(3'd7, '0);
    push(3'd0, '0);
    repeat (10) @(negedge clk);
    checks++;
    if (disp_buf !== d0) begin errors++; $display("FAIL flip_early disp=%0d want %0d", disp_buf, d0); end
    @(posedge clk); #1;
    hold_done = 0;
    wait_idle();
    checks++;
    if (disp_buf !== ~d0 || job_type !== 1'b0 || job_y_offset !== (d0 ? 9'd240 : 9'd0)) begin
      errors++;
      $display("FAIL flip_clear disp=%0d type=%0d off=%0d want %0d 0 %0d",
               disp_buf, job_type, job_y_offset, ~d0, d0 ? 240 : 0);
    end
  endtask

  task automatic test_spurious();
    spur = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || job_start !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle busy=%0d start=%0d want 0 0", busy, job_start);
    end
    @(posedge clk); #1;
    push(3'd3, 24'($urandom));
    push(3'd1, 24'($urandom));
    repeat (3) @(posedge clk); #1;
    spur = 0;
    push(3'd6, '0);
    wait_idle();
    hold_done = 1;
    push(3'd6, '0);
    wait_job();
    for (int i = 0; i < 4; i++) push(rnd_set_op(), 24'($urandom));
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0d want 0", cmd_ready); end
    @(posedge clk); #1;
    hold_done = 0;
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op = rnd_set_op();
      logic [23:0] d  = 24'($urandom);
      cmd_valid = 1'b1; cmd_data = {op, d};
      @(negedge clk);
      if (cmd_ready) apply(op, d);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    push(3'd6, '0);
    wait_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 9);
      logic [2:0] op = (r < 6) ? rnd_set_op() : (r < 8) ? 3'd6 : (r == 8) ? 3'd0 : 3'd7;
      push(op, 24'($urandom));
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_draw();
    test_fifo_full();
    test_move();
    test_flip_order();
    test_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
